// File: rtl/cla_prefix_seq.sv
// cla_prefix_seq: sequential 64-bit carry-lookahead adder built around one shared
// Kogge-Stone style prefix level. The level is applied once per cycle with span 2^j.
// Optional macro CLA_EARLY_EXIT_EN: leave the LEVEL state as soon as no entry is still
// propagate, which gives a data-dependent latency. Sum/cout are the same in both builds.
module cla_prefix_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic        busy,
    output logic        done,
    output logic [63:0] sum,
    output logic        cout
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLevel  = 2'd1;
    localparam logic [1:0] StFinish = 2'd2;

    // Per-bit carry status: kill, propagate, generate
    localparam logic [1:0] EncK = 2'b00;
    localparam logic [1:0] EncP = 2'b01;
    localparam logic [1:0] EncG = 2'b10;

    logic [1:0]       r_state;
    logic [2:0]       r_j;
    logic [63:0][1:0] r_vec;
    logic [63:0]      r_p;
    logic             r_cin;
    logic [63:0]      r_sum;
    logic             r_cout;
    logic             r_done;

    logic [63:0][1:0] w_init;
    logic [63:0][1:0] w_next;
    logic [5:0]       w_span;
    logic [63:0]      w_sum;
    logic             w_last;

    // Initial status vector; bit 0 has no predecessor so cin resolves it directly
    always_comb begin
        w_init = '0;
        for (int i = 0; i < 64; i++) begin
            if (a[i] & b[i]) begin
                w_init[i] = EncG;
            end else if (a[i] ^ b[i]) begin
                w_init[i] = EncP;
            end else begin
                w_init[i] = EncK;
            end
        end
        if (w_init[0] == EncP) begin
            w_init[0] = cin ? EncG : EncK;
        end
    end

    // One prefix level: a propagate entry inherits the status 2^j positions below
    always_comb begin
        w_span = 6'd1 << r_j;
        w_next = r_vec;
        for (int i = 0; i < 64; i++) begin
            if ((6'(i) >= w_span) && (r_vec[i] == EncP)) begin
                w_next[i] = r_vec[6'(i) - w_span];
            end
        end
    end

`ifdef CLA_EARLY_EXIT_EN
    logic w_any_p;

    // Stop iterating once every carry is resolved after this level
    always_comb begin
        w_any_p = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (w_next[i] == EncP) begin
                w_any_p = 1'b1;
            end
        end
        w_last = (r_j == 3'd5) || !w_any_p;
    end
`else
    assign w_last = (r_j == 3'd5);
`endif

    // Final sum: carry into bit i is "entry i-1 generates"
    always_comb begin
        w_sum    = '0;
        w_sum[0] = r_p[0] ^ r_cin;
        for (int i = 1; i < 64; i++) begin
            w_sum[i] = r_p[i] ^ (r_vec[i-1] == EncG);
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_j     <= 3'd0;
            r_vec   <= '0;
            r_p     <= '0;
            r_cin   <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_vec   <= w_init;
                        r_p     <= a ^ b;
                        r_cin   <= cin;
                        r_j     <= 3'd0;
                        r_state <= StLevel;
                    end
                end
                StLevel: begin
                    r_vec <= w_next;
                    r_j   <= r_j + 3'd1;
                    if (w_last) begin
                        r_state <= StFinish;
                    end
                end
                StFinish: begin
                    r_sum   <= w_sum;
                    r_cout  <= (r_vec[63] == EncG);
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy = (r_state != StIdle);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: doc/cla_prefix_seq.md
CLA_PREFIX_SEQ -- requirements
Module: cla_prefix_seq

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: start  in  1  request one 64-bit addition; sampled only in IDLE.
REQ-004 SHALL have port: a  in  64  addend A, captured when start is accepted.
REQ-005 SHALL have port: b  in  64  addend B, captured when start is accepted.
REQ-006 SHALL have port: cin  in  1  carry-in, captured when start is accepted.
REQ-007 SHALL have port: busy  out  1  high while an addition is in progress.
REQ-008 SHALL have port: done  out  1  one-cycle pulse; sum/cout valid.
REQ-009 SHALL have port: sum  out  64  registered result, held until next done.
REQ-010 SHALL have port: cout  out  1  registered carry-out, held until next done.

Function
REQ-011 SHALL keep a 64-entry registered status vector, 2 bits/entry: K=00, P=01, G=10; 11 never produced.
REQ-012 SHALL be one shared prefix-level unit, reused once per cycle for span 2^j, j=0..5.
REQ-013 SHALL have states IDLE, LEVEL, FINISH; IDLE->LEVEL on start, LEVEL->FINISH after last level, FINISH->IDLE unconditionally.
REQ-014 SHALL, on accept edge, load entry i = G if a[i]&b[i], P if a[i]^b[i], else K; entry 0 = P resolved by cin (G if cin=1, K if cin=0); j cleared to 0.
REQ-015 SHALL, each LEVEL edge, update all i>=2^j simultaneously from the pre-edge vector: K stays K; G stays G; P takes the value of entry i-2^j; entries i<2^j unchanged.
REQ-016 SHALL increment j each LEVEL edge; at edge with j=5 move to FINISH (6 LEVEL cycles).
REQ-017 SHALL, on FINISH edge, register sum[0]=a^b^cin at bit 0, sum[i]=a[i]^b[i]^(entry i-1==G) for i>=1, cout=(entry 63==G), pulse done, return to IDLE.
REQ-018 SHALL give fixed latency: done high in the 8th cycle after start is sampled (edges: load, 6 levels, finish); busy high for the 7 cycles between.
REQ-019 SHALL ignore start while busy; a, b, cin changes while busy SHALL not affect the result.
REQ-020 SHALL accept start in the cycle done is high (IDLE), giving back-to-back operation; done then deasserts next cycle.
REQ-021 SHALL never leave any entry P after level 5 (all carries resolved).

Reset
REQ-022 SHALL, on rst edge, force state IDLE, j=0, busy=0, done=0, sum=0, cout=0, status vector all K.
REQ-023 SHALL abort any in-flight operation on rst; no done pulse for the aborted request; rst dominates start in the same cycle.

Configuration
REQ-024 SHALL support macro CLA_EARLY_EXIT_EN.
REQ-025 SHALL, with CLA_EARLY_EXIT_EN defined, go LEVEL->FINISH at any LEVEL edge whose next vector contains no P (minimum one level; latency 3..8 cycles, data-dependent).
REQ-026 SHALL, without CLA_EARLY_EXIT_EN, always execute all 6 levels (fixed latency per REQ-018); sum/cout identical in both builds.

Verification
REQ-027 SHALL test a=FFFFFFFFFFFFFFFF, b=1, cin=0 -> sum=0, cout=1, done exactly 7 edges after accept edge (macro off).
REQ-028 SHALL test a=0, b=0, cin=1 -> sum=1, cout=0; a=8000000000000000, b=8000000000000000, cin=0 -> sum=0, cout=1.
REQ-029 SHALL test start held high for 20 cycles, a/b toggling -> start ignored while busy, new op accepted in each done cycle, every result matches the operands captured at its accept.
REQ-030 SHALL test rst asserted 3 cycles after accept -> busy=0, sum=0, cout=0 next cycle, no done pulse.
REQ-031 SHALL test with CLA_EARLY_EXIT_EN: a=5, b=A, cin=0 -> sum=F, cout=0, done 3 edges after accept; a=1, b=1 -> sum=2, done 2 edges after accept.
REQ-032 SHALL run 10000 random a, b, cin in both builds and compare {cout,sum} against a+b+cin.
